lab4_start_ctrl: RTL and testbench

Avalon-MM slave that lets the HPS launch the neural-network accelerator and track its completion. It drives a parameter word and a start pulse toward the accelerator, then watches the accelerator's done line. It records completion, timeout and overrun as sticky status bits, measures the run length in clock cycles, and can raise an interrupt. It sits on the lightweight HPS-to-FPGA bridge next to the existing read-only PIO status ports and complements them.

---
 rtl/lab4_ctrl_pkg.sv | 28 ++
 rtl/lab4_start_ctrl_if.sv | 13 +
 rtl/lab4_sync_edge.sv | 29 ++
 rtl/lab4_start_ctrl.sv | 144 ++++++++++++++
 tb/tb_lab4_start_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/lab4_ctrl_pkg.sv
// Shared constants for the lab4 accelerator start controller: register map,
// CONTROL/STATUS bit positions and FSM encoding.
package lab4_ctrl_pkg;

   localparam int unsigned BUS_W  = 32;
   localparam int unsigned ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_CONTROL = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_CYCLES  = 2'd3;

   localparam int unsigned CTRL_START  = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;

   localparam int unsigned STAT_BUSY     = 0;
   localparam int unsigned STAT_DONE     = 1;
   localparam int unsigned STAT_TIMEOUT  = 2;
   localparam int unsigned STAT_OVERRUN  = 3;
   localparam int unsigned STAT_DONE_LVL = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/lab4_start_ctrl_if.sv
// Avalon-MM slave bus bundle (word addressed, write-only strobe, registered read data).
interface lab4_start_ctrl_if;

   logic [lab4_ctrl_pkg::ADDR_W-1:0] address;
   logic                             chipselect;
   logic                             write_n;
   logic [lab4_ctrl_pkg::BUS_W-1:0]  writedata;
   logic [lab4_ctrl_pkg::BUS_W-1:0]  readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/lab4_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a rising-edge strobe.
module lab4_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic sync_d_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         sync_d_q <= 1'b0;
      end else begin
         meta_q   <= async_i;
         sync_q   <= meta_q;
         sync_d_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~sync_d_q;

endmodule

// File: rtl/lab4_start_ctrl.sv
// HPS-facing launch/completion controller for the NN accelerator: parameter
// word, start pulse, sticky status, run-length counter and level interrupt.
module lab4_start_ctrl
   import lab4_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned PULSE_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset_n,
   lab4_start_ctrl_if.slave  bus,
   input  logic              done_in,
   output logic              start_out,
   output logic [DATA_W-1:0] out_port,
   output logic              irq
);

   localparam int unsigned PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_CYCLES - 1);

   state_e              state_q;
   logic [PCNT_W-1:0]   pulse_cnt_q;
   logic [BUS_W-1:0]    run_cnt_q;
   logic [BUS_W-1:0]    cycles_q;
   logic [DATA_W-1:0]   data_q;
   logic [BUS_W-1:0]    rdata_q;
   logic                start_q;
   logic                irq_en_q;
   logic                done_q;
   logic                timeout_q;
   logic                overrun_q;

   logic                done_lvl;
   logic                done_rise;
   logic                wr_en, wr_data, wr_ctrl, wr_stat;
   logic                start_req, busy, timeout_hit;
   logic [BUS_W-1:0]    status_w;
   logic                unused_wdata;

   lab4_sync_edge u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (done_in),
      .sync_o  (done_lvl),
      .rise_o  (done_rise)
   );

   // Bus decode and status word assembly
   always_comb begin
      wr_en       = bus.chipselect & ~bus.write_n;
      wr_data     = wr_en && (bus.address == ADDR_DATA);
      wr_ctrl     = wr_en && (bus.address == ADDR_CONTROL);
      wr_stat     = wr_en && (bus.address == ADDR_STATUS);
      start_req   = wr_ctrl & bus.writedata[CTRL_START];
      busy        = (state_q != ST_IDLE);
      timeout_hit = (TIMEOUT_CYCLES != 0) && (run_cnt_q == BUS_W'(TIMEOUT_CYCLES));

      status_w                = '0;
      status_w[STAT_BUSY]     = busy;
      status_w[STAT_DONE]     = done_q;
      status_w[STAT_TIMEOUT]  = timeout_q;
      status_w[STAT_OVERRUN]  = overrun_q;
      status_w[STAT_DONE_LVL] = done_lvl;
   end

   assign unused_wdata = ^bus.writedata;

   // Registers and run FSM; hardware sets are written after W1C clears so they win
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         pulse_cnt_q <= '0;
         run_cnt_q   <= '0;
         cycles_q    <= '0;
         data_q      <= '0;
         rdata_q     <= '0;
         start_q     <= 1'b0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (wr_data) data_q   <= bus.writedata[DATA_W-1:0];
         if (wr_ctrl) irq_en_q <= bus.writedata[CTRL_IRQ_EN];
         if (wr_stat) begin
            if (bus.writedata[STAT_DONE])    done_q    <= 1'b0;
            if (bus.writedata[STAT_TIMEOUT]) timeout_q <= 1'b0;
            if (bus.writedata[STAT_OVERRUN]) overrun_q <= 1'b0;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (start_req) begin
                  state_q     <= ST_PULSE;
                  pulse_cnt_q <= PCNT_LOAD;
                  run_cnt_q   <= '0;
                  done_q      <= 1'b0;
                  timeout_q   <= 1'b0;
                  start_q     <= 1'b1;
               end
            end
            ST_PULSE, ST_WAIT: begin
               if (run_cnt_q != '1) run_cnt_q <= run_cnt_q + BUS_W'(1);
               if (start_req) overrun_q <= 1'b1;
               if (done_rise) begin
                  state_q  <= ST_IDLE;
                  start_q  <= 1'b0;
                  done_q   <= 1'b1;
                  cycles_q <= run_cnt_q;
               end else if (timeout_hit) begin
                  state_q   <= ST_IDLE;
                  start_q   <= 1'b0;
                  timeout_q <= 1'b1;
               end else if (state_q == ST_PULSE) begin
                  if (pulse_cnt_q == '0) begin
                     state_q <= ST_WAIT;
                     start_q <= 1'b0;
                  end else begin
                     pulse_cnt_q <= pulse_cnt_q - PCNT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               start_q <= 1'b0;
            end
         endcase

         unique case (bus.address)
            ADDR_DATA:    rdata_q <= BUS_W'(data_q);
            ADDR_CONTROL: rdata_q <= BUS_W'({irq_en_q, 1'b0});
            ADDR_STATUS:  rdata_q <= status_w;
            default:      rdata_q <= cycles_q;
         endcase
      end
   end

   assign bus.readdata = rdata_q;
   assign start_out    = start_q;
   assign out_port     = data_q;
   assign irq          = irq_en_q & (done_q | timeout_q);

endmodule

// File: tb/tb_lab4_start_ctrl.sv
// Self-checking bench for lab4_start_ctrl: register table plus run/timeout/
// overrun/W1C-race/collision/reset sequences, reads checked via a scoreboard.
module tb_lab4_start_ctrl;
   import lab4_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        done_in = 1'b0;
   logic        start_out;
   logic [15:0] out_port;
   logic        irq;

   lab4_start_ctrl_if bus ();

   lab4_start_ctrl #(
      .DATA_W         (16),
      .PULSE_CYCLES   (4),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .done_in   (done_in),
      .start_out (start_out),
      .out_port  (out_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   typedef struct {
      bit          is_wr;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   // Expected value is queued when the address is driven, popped when readdata is valid
   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      logic [31:0] e;
      string       n;
      @(negedge clk);
      bus.address = a;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(negedge clk);
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, bus.readdata, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;

      vecs[0]  = '{1'b0, ADDR_DATA,    32'h0,        32'h0,      "rst_data"};
      vecs[1]  = '{1'b0, ADDR_CONTROL, 32'h0,        32'h0,      "rst_ctrl"};
      vecs[2]  = '{1'b0, ADDR_STATUS,  32'h0,        32'h0,      "rst_status"};
      vecs[3]  = '{1'b0, ADDR_CYCLES,  32'h0,        32'h0,      "rst_cycles"};
      vecs[4]  = '{1'b1, ADDR_DATA,    32'hFFFF1234, 32'h0,      ""};
      vecs[5]  = '{1'b0, ADDR_DATA,    32'h0,        32'h1234,   "data_upper0"};
      vecs[6]  = '{1'b1, ADDR_CONTROL, 32'h2,        32'h0,      ""};
      vecs[7]  = '{1'b0, ADDR_CONTROL, 32'h0,        32'h2,      "ctrl_irqen"};
      vecs[8]  = '{1'b1, ADDR_CONTROL, 32'h0,        32'h0,      ""};
      vecs[9]  = '{1'b1, ADDR_CYCLES,  32'hDEAD,     32'h0,      ""};
      vecs[10] = '{1'b0, ADDR_CYCLES,  32'h0,        32'h0,      "cycles_ro"};
      vecs[11] = '{1'b1, ADDR_STATUS,  32'h1F,       32'h0,      ""};

      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;

      repeat (3) @(negedge clk);
      chk("rst_start_out", 32'(start_out), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_out_port", 32'(out_port), 32'h0);
      chk("rst_readdata", bus.readdata, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
         else               rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end
      rd(ADDR_STATUS, 32'h0, "status_after_w1c_idle");

      // Normal run
      wr(ADDR_DATA, 32'h0000_00A5);
      chk("out_port", 32'(out_port), 32'h00A5);
      wr(ADDR_CONTROL, 32'h3);
      chk("start_first_cycle", 32'(start_out), 32'h1);
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         hi += int'(start_out);
         @(negedge clk);
      end
      chk("start_pulse_len", 32'(hi), 32'd4);
      repeat (12) @(negedge clk);
      done_in = 1'b1;
      repeat (5) @(negedge clk);
      rd(ADDR_STATUS, 32'h12, "run_status");
      rd(ADDR_CYCLES, 32'd22, "run_cycles");
      rd(ADDR_CONTROL, 32'h2, "ctrl_start_reads0");
      chk("run_irq", 32'(irq), 32'h1);

      // Timeout
      done_in = 1'b0;
      repeat (4) @(negedge clk);
      wr(ADDR_STATUS, 32'h2);
      chk("w1c_irq_drop", 32'(irq), 32'h0);
      wr(ADDR_CONTROL, 32'h3);
      repeat (40) @(negedge clk);
      rd(ADDR_STATUS, 32'h01, "to_busy");
      repeat (20) @(negedge clk);
      rd(ADDR_STATUS, 32'h04, "to_status");
      rd(ADDR_CYCLES, 32'd22, "to_cycles_kept");
      chk("to_irq", 32'(irq), 32'h1);

      // Overrun: second START mid-pulse must not retrigger
      wr(ADDR_CONTROL, 32'h3);
      hi = int'(start_out);
      bus.address    = ADDR_CONTROL;
      bus.writedata  = 32'h3;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      hi += int'(start_out);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         hi += int'(start_out);
      end
      chk("ovr_pulse_len", 32'(hi), 32'd4);
      rd(ADDR_STATUS, 32'h09, "ovr_busy");
      done_in = 1'b1;
      repeat (6) @(negedge clk);
      rd(ADDR_STATUS, 32'h1A, "ovr_done");
      wr(ADDR_STATUS, 32'h08);
      rd(ADDR_STATUS, 32'h12, "ovr_cleared");
      done_in = 1'b0;
      repeat (4) @(negedge clk);

      // W1C of DONE in the same cycle done_rise sets it
      wr(ADDR_CONTROL, 32'h3);
      repeat (10) @(negedge clk);
      done_in = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus.address    = ADDR_STATUS;
      bus.writedata  = 32'h2;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      repeat (2) @(negedge clk);
      rd(ADDR_STATUS, 32'h12, "race_done_kept");
      chk("race_irq", 32'(irq), 32'h1);
      wr(ADDR_STATUS, 32'h2);
      rd(ADDR_STATUS, 32'h10, "race_cleared");
      chk("race_irq_drop", 32'(irq), 32'h0);
      done_in = 1'b0;
      repeat (4) @(negedge clk);

      // done_rise lands on the timeout count
      wr(ADDR_CONTROL, 32'h3);
      repeat (48) @(negedge clk);
      done_in = 1'b1;
      repeat (6) @(negedge clk);
      rd(ADDR_STATUS, 32'h12, "coll_status");
      rd(ADDR_CYCLES, 32'd50, "coll_cycles");
      done_in = 1'b0;
      repeat (4) @(negedge clk);

      // Reset mid-pulse
      wr(ADDR_CONTROL, 32'h3);
      chk("mid_start_high", 32'(start_out), 32'h1);
      #1 reset_n = 1'b0;
      #1 chk("mid_rst_start_low", 32'(start_out), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) rd(vecs[i].addr, vecs[i].exp, {"post_", vecs[i].name});
      chk("post_out_port", 32'(out_port), 32'h0);
      chk("post_irq", 32'(irq), 32'h0);

      // done_rise in IDLE is ignored
      done_in = 1'b1;
      repeat (4) @(negedge clk);
      rd(ADDR_STATUS, 32'h10, "idle_done_ignored");
      chk("idle_irq", 32'(irq), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
